chart_sequencer: RTL and testbench

Game-level sequencer for the two-lane (red/blue) rhythm game on the LED matrix. Divides clk into beat steps and walks a chart ROM one entry per step. Emits shift pulses and spawn bits to the note shift datapath, and gates the hit judge via `playing`. Runs the game flow: idle, count-in, play, drain, done, with pause.

---
 rtl/chart_sequencer.sv | 119 +++++++++++
 tb/tb_chart_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// chart_sequencer: beat-step game sequencer that walks a chart ROM and drives the note shift datapath.
// Optional LOOP_CHART_EN: the chart repeats endlessly in PLAY and a start pulse ends the game via DRAIN.
module chart_sequencer #(
    parameter int TICK_DIV      = 2500000,
    parameter int CHART_LEN     = 64,
    parameter int ADDR_W        = 6,
    parameter int COUNTIN_STEPS = 4,
    parameter int DRAIN_STEPS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause_toggle,
    input  logic [1:0]        chart_data,
    output logic [ADDR_W-1:0] chart_addr,
    output logic              shift_en,
    output logic              spawn_red,
    output logic              spawn_blue,
    output logic              playing,
    output logic              paused,
    output logic              done,
    output logic [2:0]        state
);
`ifdef LOOP_CHART_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam int PW   = $clog2(TICK_DIV);
    localparam int SMAX = COUNTIN_STEPS > DRAIN_STEPS ? COUNTIN_STEPS : DRAIN_STEPS;
    localparam int SW   = $clog2(SMAX + 1);
    typedef enum logic [2:0] {IDLE, COUNTIN, PLAY, DRAIN, DONE, PAUSE} state_t;
    state_t            state_q, state_d, resume_q, resume_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     step_q, step_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              shift_q, shift_d, red_q, red_d, blue_q, blue_d, stop_q, stop_d;
    logic              run, tick, last;
    assign run  = state_q == COUNTIN || state_q == PLAY || state_q == DRAIN;
    assign tick = run && presc_q == PW'(TICK_DIV - 1);
    assign last = addr_q == ADDR_W'(CHART_LEN - 1);
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        presc_d  = run ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        step_d   = step_q;
        addr_d   = addr_q;
        stop_d   = stop_q;
        shift_d  = 1'b0;
        red_d    = 1'b0;
        blue_d   = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = COUNTIN;
                presc_d = '0;
                step_d  = '0;
                addr_d  = '0;
                stop_d  = 1'b0;
            end
            COUNTIN: if (tick) begin
                step_d  = step_q == SW'(COUNTIN_STEPS - 1) ? '0 : step_q + 1'b1;
                state_d = step_q == SW'(COUNTIN_STEPS - 1) ? PLAY : COUNTIN;
            end
            PLAY: begin
                stop_d = stop_q | (LOOP & start);
                if (tick) begin
                    shift_d = 1'b1;
                    red_d   = chart_data[1];
                    blue_d  = chart_data[0];
                    if (stop_d || (last && !LOOP)) state_d = DRAIN;
                    else addr_d = last ? '0 : addr_q + 1'b1;
                end
            end
            DRAIN: if (tick) begin
                shift_d = 1'b1;
                step_d  = step_q == SW'(DRAIN_STEPS - 1) ? '0 : step_q + 1'b1;
                state_d = step_q == SW'(DRAIN_STEPS - 1) ? DONE : DRAIN;
            end
            PAUSE: if (pause_toggle) state_d = resume_q;
            default: state_d = IDLE;
        endcase
        // the step of this cycle is taken first; pausing saves where it led
        if (run && pause_toggle && state_d != DONE) begin
            resume_d = state_d;
            state_d  = PAUSE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            resume_q <= IDLE;
            presc_q  <= '0;
            step_q   <= '0;
            addr_q   <= '0;
            stop_q   <= 1'b0;
            shift_q  <= 1'b0;
            red_q    <= 1'b0;
            blue_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            addr_q   <= addr_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            red_q    <= red_d;
            blue_q   <= blue_d;
        end
    end
    assign chart_addr = addr_q;
    assign shift_en   = shift_q;
    assign spawn_red  = red_q;
    assign spawn_blue = blue_q;
    assign playing    = state_q == PLAY || state_q == DRAIN;
    assign paused     = state_q == PAUSE;
    assign done       = state_q == DONE;
    assign state      = state_q;
endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer: scoreboard bench; expected shift pulses are queued with their cycle, a monitor pops them.
module tb_chart_sequencer;
    logic       clk = 1'b0, rst, start, pause_toggle;
    logic [1:0] chart_data;
    logic [1:0] chart_addr;
    logic       shift_en, spawn_red, spawn_blue, playing, paused, done;
    logic [2:0] state;
    logic [1:0] rom [4];
    int         cyc = 0, checks = 0, errors = 0, s;
    typedef struct {logic [1:0] sp; int cy;} exp_t;
    exp_t q[$];

    chart_sequencer #(.TICK_DIV(4), .CHART_LEN(4), .ADDR_W(2), .COUNTIN_STEPS(2), .DRAIN_STEPS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pause_toggle(pause_toggle), .chart_data(chart_data),
        .chart_addr(chart_addr), .shift_en(shift_en), .spawn_red(spawn_red), .spawn_blue(spawn_blue),
        .playing(playing), .paused(paused), .done(done), .state(state));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        rom[0] = 2'b10; rom[1] = 2'b01; rom[2] = 2'b11; rom[3] = 2'b00;
    end
    always @(posedge clk) chart_data <= rom[chart_addr];

    always @(negedge clk) if (shift_en) begin
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL pulse: unexpected shift_en at cycle %0d spawn=%b", cyc, {spawn_red, spawn_blue});
        end else begin
            exp_t e;
            e = q.pop_front();
            if ({spawn_red, spawn_blue} != e.sp || cyc != e.cy) begin
                errors++;
                $display("FAIL pulse: got spawn=%b at cycle %0d, expected spawn=%b at cycle %0d",
                         {spawn_red, spawn_blue}, cyc, e.sp, e.cy);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic push(input logic [1:0] sp, input int cy);
        exp_t e;
        e.sp = sp;
        e.cy = cy;
        q.push_back(e);
    endtask
    task automatic push_game(input int b);
        push(2'b10, b + 12); push(2'b01, b + 16); push(2'b11, b + 20); push(2'b00, b + 24);
        push(2'b00, b + 28); push(2'b00, b + 32); push(2'b00, b + 36);
    endtask
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask
    task automatic do_start(output int b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = cyc;
    endtask
    task automatic do_pause();
        pause_toggle = 1'b1;
        @(negedge clk);
        pause_toggle = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause_toggle = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_outs", int'({chart_addr, shift_en, spawn_red, spawn_blue, playing, paused, done}), 0);
        rst = 1'b0;
        // normal game
        wait_cyc(9);
        do_start(s);
        push_game(s);
        wait_cyc(s + 4);
        chk("countin_state", int'(state), 1);
        chk("countin_playing", int'(playing), 0);
        wait_cyc(s + 13);
        chk("play_state", int'(state), 2);
        chk("play_playing", int'(playing), 1);
        wait_cyc(s + 37);
        chk("t1_done", int'(done), 1);
        chk("t1_state", int'(state), 4);
        do_pause();
        chk("done_pause_ignored", int'(state), 4);
        // pause after the 2nd pulse for 20 cycles
        do_start(s);
        push(2'b10, s + 12); push(2'b01, s + 16); push(2'b11, s + 40); push(2'b00, s + 44);
        push(2'b00, s + 48); push(2'b00, s + 52); push(2'b00, s + 56);
        wait_cyc(s + 16);
        do_pause();
        wait_cyc(s + 27);
        chk("pause_state", int'(state), 5);
        chk("pause_paused", int'(paused), 1);
        chk("pause_playing", int'(playing), 0);
        wait_cyc(s + 36);
        do_pause();
        chk("resume_state", int'(state), 2);
        wait_cyc(s + 57);
        chk("t2_done", int'(done), 1);
        // pause coincident with a tick
        do_start(s);
        push(2'b10, s + 12); push(2'b01, s + 16); push(2'b11, s + 24); push(2'b00, s + 28);
        push(2'b00, s + 32); push(2'b00, s + 36); push(2'b00, s + 40);
        wait_cyc(s + 15);
        do_pause();
        chk("tick_pause_state", int'(state), 5);
        chk("tick_pause_addr", int'(chart_addr), 2);
        wait_cyc(s + 19);
        do_pause();
        wait_cyc(s + 41);
        chk("t3_done", int'(done), 1);
        // reset mid-PLAY
        do_start(s);
        push(2'b10, s + 12); push(2'b01, s + 16);
        wait_cyc(s + 18);
        chk("pre_rst_addr", int'(chart_addr), 2);
        rst = 1'b1;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_outs", int'({chart_addr, shift_en, spawn_red, spawn_blue, playing, paused, done}), 0);
        @(negedge clk);
        rst = 1'b0;
        // replay with a start pulse during PLAY
        do_start(s);
`ifdef LOOP_CHART_EN
        push(2'b10, s + 12); push(2'b01, s + 16); push(2'b11, s + 20); push(2'b00, s + 24);
        push(2'b10, s + 28); push(2'b00, s + 32); push(2'b00, s + 36); push(2'b00, s + 40);
        wait_cyc(s + 25);
        do_start(s);
        s = s - 26;
        wait_cyc(s + 41);
`else
        push_game(s);
        wait_cyc(s + 25);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 37);
`endif
        chk("t5_done", int'(done), 1);
        // start with pause_toggle in DONE
        start = 1'b1; pause_toggle = 1'b1;
        @(negedge clk);
        start = 1'b0; pause_toggle = 1'b0;
        s = cyc;
        push_game(s);
        chk("t6_state", int'(state), 1);
        chk("t6_addr", int'(chart_addr), 0);
        chk("t6_paused", int'(paused), 0);
        wait_cyc(s + 37);
        chk("t6_done", int'(done), 1);
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
